// File: rtl/reg_file_sb.sv
// reg_file_sb: 32 x 32-bit register file with a per-register busy scoreboard.
// Two combinational read ports, one write port, RAW hazard flags and a
// registered busy population count.
// Optional feature: define REGFILE_BYPASS_EN for write-through read bypass.
module reg_file_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              wr_ok;

    // Population count over the busy vector.
    function automatic logic [CNT_W-1:0] popcnt(input logic [NREG-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign wr_ok = we && (wa != '0);

    // Next scoreboard state: writeback clears, issue sets (set wins), r0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (we) begin
            busy_nxt[wa] = 1'b0;
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
        cnt_nxt     = popcnt(busy_nxt);
    end

    // Register array, scoreboard and busy count; reset overrides write and issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok) begin
                regs[wa] <= wd;
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Combinational read ports and hazard flags; r0 reads as zero.
    always_comb begin
        rd1     = (ra1 == '0) ? '0 : regs[ra1];
        rd2     = (ra2 == '0) ? '0 : regs[ra2];
        hazard1 = busy[ra1];
        hazard2 = busy[ra2];
`ifdef REGFILE_BYPASS_EN
        // Same-cycle writeback forwards data and retires the hazard unless reissued.
        if (wr_ok && (wa == ra1)) begin
            rd1     = wd;
            hazard1 = issue_en && (issue_rd == ra1);
        end
        if (wr_ok && (wa == ra2)) begin
            rd2     = wd;
            hazard2 = issue_en && (issue_rd == ra2);
        end
`else
        // Without bypass the old value and busy bit stay visible until the edge.
`endif
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb; expected values are hand-computed constants.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        hazard1;
    logic        hazard2;
    logic [5:0]  busy_cnt;

    int total;
    int bad;

    reg_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count a comparison and report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge to sample outputs.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        we       = 1'b0;
        wa       = '0;
        wd       = '0;
        issue_en = 1'b0;
        issue_rd = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        ra1   = '0;
        ra2   = '0;
        idle();

        // Reset for two cycles, then scan every address.
        step();
        step();
        rst = 1'b0;
        mid();
        chk("rst_busy_cnt", 32'(busy_cnt), 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rd1, 32'd0);
            chk("rst_rd2", rd2, 32'd0);
            chk("rst_hz1", 32'(hazard1), 32'd0);
            chk("rst_hz2", 32'(hazard2), 32'd0);
        end

        // Basic write/read on both ports.
        step();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        idle();
        ra1 = 5'd5; ra2 = 5'd5;
        mid();
        chk("wr5_rd1", rd1, 32'hDEADBEEF);
        chk("wr5_rd2", rd2, 32'hDEADBEEF);

        // Write to r0 is dropped.
        step();
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        step();
        idle();
        ra1 = 5'd0; ra2 = 5'd0;
        mid();
        chk("r0_rd1", rd1, 32'd0);
        chk("r0_rd2", rd2, 32'd0);

        // Issue to r0 never marks busy.
        step();
        issue_en = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        mid();
        chk("iss0_hz1", 32'(hazard1), 32'd0);
        chk("iss0_cnt", 32'(busy_cnt), 32'd0);

        // Issue r7 -> hazard; writeback r7 -> hazard clears.
        step();
        issue_en = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        ra2 = 5'd7;
        mid();
        chk("iss7_hz2", 32'(hazard2), 32'd1);
        chk("iss7_cnt", 32'(busy_cnt), 32'd1);
        step();
        we = 1'b1; wa = 5'd7; wd = 32'h55;
        mid();
`ifdef REGFILE_BYPASS_EN
        chk("wb7_hz2_same", 32'(hazard2), 32'd0);
        chk("wb7_rd2_same", rd2, 32'h55);
`else
        chk("wb7_hz2_same", 32'(hazard2), 32'd1);
        chk("wb7_rd2_same", rd2, 32'd0);
`endif
        step();
        idle();
        mid();
        chk("wb7_hz2", 32'(hazard2), 32'd0);
        chk("wb7_rd2", rd2, 32'h55);
        chk("wb7_cnt", 32'(busy_cnt), 32'd0);

        // Busy r9, then same-cycle issue and writeback of r9: set wins.
        step();
        issue_en = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        mid();
        chk("iss9_cnt", 32'(busy_cnt), 32'd1);
        step();
        issue_en = 1'b1; issue_rd = 5'd9;
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        step();
        idle();
        ra1 = 5'd9;
        mid();
        chk("iw9_hz1", 32'(hazard1), 32'd1);
        chk("iw9_rd1", rd1, 32'h99);
        chk("iw9_cnt", 32'(busy_cnt), 32'd1);
        step();
        we = 1'b1; wa = 5'd9; wd = 32'h98;
        step();
        idle();
        mid();
        chk("clr9_hz1", 32'(hazard1), 32'd0);
        chk("clr9_cnt", 32'(busy_cnt), 32'd0);

        // Bypass window on r3 with prior value 1.
        step();
        we = 1'b1; wa = 5'd3; wd = 32'h1;
        step();
        ra1 = 5'd3;
        wd  = 32'hA5A5A5A5;
        mid();
`ifdef REGFILE_BYPASS_EN
        chk("byp3_same", rd1, 32'hA5A5A5A5);
`else
        chk("byp3_same", rd1, 32'h1);
`endif
        step();
        idle();
        mid();
        chk("byp3_next", rd1, 32'hA5A5A5A5);

        // Build busy r4/r6 with R[4]=FF, then reset together with a write.
        step();
        we = 1'b1; wa = 5'd4; wd = 32'hFF;
        issue_en = 1'b1; issue_rd = 5'd6;
        step();
        idle();
        issue_en = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        ra1 = 5'd4; ra2 = 5'd6;
        mid();
        chk("pre_rd1", rd1, 32'hFF);
        chk("pre_hz1", 32'(hazard1), 32'd1);
        chk("pre_hz2", 32'(hazard2), 32'd1);
        chk("pre_cnt", 32'(busy_cnt), 32'd2);
        step();
        rst = 1'b1;
        we = 1'b1; wa = 5'd4; wd = 32'h123;
        issue_en = 1'b1; issue_rd = 5'd8;
        step();
        rst = 1'b0;
        idle();
        mid();
        chk("mrst_rd1", rd1, 32'd0);
        chk("mrst_hz1", 32'(hazard1), 32'd0);
        chk("mrst_hz2", 32'(hazard2), 32'd0);
        chk("mrst_cnt", 32'(busy_cnt), 32'd0);
        ra2 = 5'd8;
        #1;
        chk("mrst_hz8", 32'(hazard2), 32'd0);
        ra2 = 5'd3;
        #1;
        chk("mrst_rd3", rd2, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
